// File: rtl/hazard_pkg.sv
// hazard_pkg: shared opcode-class constants, forwarding-select encodings and
// the shadow-pipeline entry type for the hazard controller.
package hazard_pkg;

  // RV32I major opcodes, inst[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;

  // EX operand source selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Shadow stage indices
  localparam int NSTG    = 3;
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  typedef struct packed {
    logic       valid;
    logic       writes;   // writes a non-zero rd
    logic       is_load;
    logic [4:0] rd;
  } shadow_t;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes;         // class writes rd (rd==0 not yet excluded)
    logic is_load;
  } opc_class_t;

  // Youngest-producer-wins operand select from per-stage match bits
  function automatic logic [1:0] fwd_pick(input logic act,
                                          input logic [NSTG-1:0] m);
    if (!act)              return FWD_RF;
    else if (m[STG_EX])    return FWD_EXMEM;
    else if (m[STG_MEM])   return FWD_MEMWB;
    else                   return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX-side signals of the hazard controller.
// master = the pipeline driving decoded fields, slave = hazard_ctrl.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             id_valid;
  logic [4:0]       id_opcode;
  logic [4:0]       id_rs1_index;
  logic [4:0]       id_rs2_index;
  logic [4:0]       id_rd_index;
  logic             ex_branch_taken;
  logic             stall_if;
  logic             stall_id;
  logic             flush_id;
  logic             flush_ex;
  logic             issue;
  logic [1:0]       fwd_rs1_sel;
  logic [1:0]       fwd_rs2_sel;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_opcode, id_rs1_index, id_rs2_index, id_rd_index,
           ex_branch_taken,
    input  stall_if, stall_id, flush_id, flush_ex, issue,
           fwd_rs1_sel, fwd_rs2_sel, stall_cycles
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1_index, id_rs2_index, id_rd_index,
           ex_branch_taken,
    output stall_if, stall_id, flush_id, flush_ex, issue,
           fwd_rs1_sel, fwd_rs2_sel, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_opcode_class.sv
// opcode_class: maps an RV32I opcode to its register-usage class.
// Unknown opcodes read and write nothing, so they never stall.
module opcode_class
  import hazard_pkg::*;
(
  input  logic [4:0] opcode_i,
  output opc_class_t cls_o
);

  // Opcode decode into source-use / write / load flags
  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OPC_BRANCH, OPC_STORE: begin
        cls_o.uses_rs1 = 1'b1;
        cls_o.uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        cls_o.uses_rs1 = 1'b1;
        cls_o.uses_rs2 = 1'b1;
        cls_o.writes   = 1'b1;
      end
      OPC_JALR, OPC_OPIMM: begin
        cls_o.uses_rs1 = 1'b1;
        cls_o.writes   = 1'b1;
      end
      OPC_LOAD: begin
        cls_o.uses_rs1 = 1'b1;
        cls_o.writes   = 1'b1;
        cls_o.is_load  = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        cls_o.writes   = 1'b1;
      end
      default: cls_o = '0;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage hazard / sequencing controller for the 5-stage core.
// Keeps a shadow {valid,writes,is_load,rd} of EX/MEM/WB and derives stall,
// flush, issue, EX forwarding selects and a saturating stall counter.
// Build option: FORWARDING_EN -- when defined, only load-use stalls and the
// forwarding selects are live; otherwise any EX/MEM RAW stalls and the
// selects are tied to the register file.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave hif
);

  opc_class_t               cls;
  shadow_t [NSTG-1:0]       sh_q, sh_d;
  logic    [NSTG-1:0]       m1, m2, ld_vec;
  logic                     rs1_act, rs2_act;
  logic                     load_use, hazard;
  logic                     stall, brk, issue;
  logic    [CNT_W-1:0]      cnt_q, cnt_d;

  opcode_class u_cls (
    .opcode_i (hif.id_opcode),
    .cls_o    (cls)
  );

  assign rs1_act = cls.uses_rs1 & (hif.id_rs1_index != 5'd0);
  assign rs2_act = cls.uses_rs2 & (hif.id_rs2_index != 5'd0);

  // Per-stage producer match against each ID source
  for (genvar s = 0; s < NSTG; s++) begin : g_match
    assign m1[s]     = sh_q[s].valid & sh_q[s].writes & (sh_q[s].rd == hif.id_rs1_index);
    assign m2[s]     = sh_q[s].valid & sh_q[s].writes & (sh_q[s].rd == hif.id_rs2_index);
    assign ld_vec[s] = sh_q[s].is_load;
  end

  // Load in EX feeding a live source: the value is not available until MEM/WB
  assign load_use = ld_vec[STG_EX] & ((rs1_act & m1[STG_EX]) | (rs2_act & m2[STG_EX]));

`ifdef FORWARDING_EN
  // Everything except load-use is covered by the bypass network
  assign hazard = load_use;
`else
  // No bypass: wait until the producer reaches WB (write-through regfile).
  // load_use is a subset of the EX match; kept so both builds share one term.
  localparam logic [NSTG-1:0] HZ_STAGES = 3'b011;
  assign hazard = load_use
                | (rs1_act & |(m1 & HZ_STAGES))
                | (rs2_act & |(m2 & HZ_STAGES));
`endif

  // A taken branch always wins over a stall; reset silences all controls
  assign brk   = ~rst & hif.ex_branch_taken;
  assign stall = ~rst & hif.id_valid & hazard & ~hif.ex_branch_taken;
  assign issue = ~rst & hif.id_valid & ~hazard & ~hif.ex_branch_taken;

  assign hif.stall_if = stall;
  assign hif.stall_id = stall;
  assign hif.flush_id = brk;
  assign hif.flush_ex = stall | brk;
  assign hif.issue    = issue;

  // Shadow advance: EX takes the issuing instruction or a bubble
  always_comb begin
    sh_d              = '0;
    if (issue) begin
      sh_d[STG_EX].valid   = 1'b1;
      sh_d[STG_EX].writes  = cls.writes & (hif.id_rd_index != 5'd0);
      sh_d[STG_EX].is_load = cls.is_load;
      sh_d[STG_EX].rd      = hif.id_rd_index;
    end
    sh_d[STG_MEM] = sh_q[STG_EX];
    sh_d[STG_WB]  = sh_q[STG_MEM];
  end

  // Saturating stall counter next state
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Shadow pipeline and stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign hif.stall_cycles = cnt_q;

`ifdef FORWARDING_EN
  logic [1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;

  // Selects are resolved at ID and travel with the instruction into EX
  always_comb begin
    fwd1_d = FWD_RF;
    fwd2_d = FWD_RF;
    if (issue) begin
      fwd1_d = fwd_pick(rs1_act, m1);
      fwd2_d = fwd_pick(rs2_act, m2);
    end
  end

  // Forwarding select registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd1_q <= FWD_RF;
      fwd2_q <= FWD_RF;
    end else begin
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
    end
  end

  assign hif.fwd_rs1_sel = fwd1_q;
  assign hif.fwd_rs2_sel = fwd2_q;
`else
  assign hif.fwd_rs1_sel = FWD_RF;
  assign hif.fwd_rs2_sel = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + randomized check of hazard_ctrl against a
// register-scoreboard model (per-register last-writer issue cycle).
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CW = 4;   // narrow counter so saturation is reached
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hif();

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model state
  int      last_iss[32];   // cycle at which the latest writer of reg r issued
  bit      last_ld[32];
  int      cyc = 0;
  int      cnt_m = 0;
  int      sel1_m = 0, sel2_m = 0;
  bit      regs_known = 1'b0;

  logic [4:0] opcs [10] = '{OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH,
                            OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, 5'b11100};

  function automatic void classify(input logic [4:0] opc, output bit u1,
                                   output bit u2, output bit wr, output bit ld);
    u1 = 0; u2 = 0; wr = 0; ld = 0;
    if (opc == OPC_BRANCH || opc == OPC_STORE || opc == OPC_OP) begin u1 = 1; u2 = 1; end
    if (opc == OPC_JALR || opc == OPC_LOAD || opc == OPC_OPIMM) u1 = 1;
    if (opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP}) wr = 1;
    ld = (opc == OPC_LOAD);
  endfunction

  function automatic bit src_hz(input bit used, input logic [4:0] rs);
    int d;
    if (!used || rs == 0) return 0;
    d = cyc - last_iss[rs];
    if (FWD) return (d == 1) && last_ld[rs];
    return (d == 1) || (d == 2);
  endfunction

  function automatic int src_sel(input bit used, input logic [4:0] rs);
    int d;
    if (!FWD || !used || rs == 0) return 0;
    d = cyc - last_iss[rs];
    if (d == 1) return 1;
    if (d == 2) return 2;
    return 0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin last_iss[r] = -100; last_ld[r] = 0; end
  endtask

  // One cycle: drive, check combinational and registered outputs, advance model
  task automatic step(input bit v, input logic [4:0] opc, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] rd, input bit br,
                      input bit r);
    bit u1, u2, wr, ld, hz, e_stall, e_issue, e_br;
    int s1, s2;
    @(negedge clk);
    rst = r;
    hif.id_valid = v; hif.id_opcode = opc; hif.id_rs1_index = r1;
    hif.id_rs2_index = r2; hif.id_rd_index = rd; hif.ex_branch_taken = br;
    #1;
    classify(opc, u1, u2, wr, ld);
    hz      = src_hz(u1, r1) || src_hz(u2, r2);
    e_br    = !r && br;
    e_stall = !r && v && hz && !br;
    e_issue = !r && v && !hz && !br;
    s1 = src_sel(u1, r1);
    s2 = src_sel(u2, r2);
    chk("stall_if", 32'(hif.stall_if), 32'(e_stall));
    chk("stall_id", 32'(hif.stall_id), 32'(e_stall));
    chk("flush_id", 32'(hif.flush_id), 32'(e_br));
    chk("flush_ex", 32'(hif.flush_ex), 32'(e_stall || e_br));
    chk("issue",    32'(hif.issue),    32'(e_issue));
    if (regs_known) begin
      chk("fwd_rs1_sel",  32'(hif.fwd_rs1_sel),  32'(sel1_m));
      chk("fwd_rs2_sel",  32'(hif.fwd_rs2_sel),  32'(sel2_m));
      chk("stall_cycles", 32'(hif.stall_cycles), 32'(cnt_m));
    end
    @(posedge clk);
    if (r) begin
      model_clear();
      cnt_m = 0; sel1_m = 0; sel2_m = 0;
      regs_known = 1'b1;
    end else begin
      sel1_m = e_issue ? s1 : 0;
      sel2_m = e_issue ? s2 : 0;
      if (e_issue && wr && rd != 0) begin last_iss[rd] = cyc; last_ld[rd] = ld; end
      if (e_stall && cnt_m < (1 << CW) - 1) cnt_m++;
      cyc++;
    end
  endtask

  // Retry an instruction until it issues (bounded)
  task automatic issue_until(input logic [4:0] opc, input logic [4:0] r1,
                             input logic [4:0] r2, input logic [4:0] rd);
    int k = 0;
    do begin
      step(1, opc, r1, r2, rd, 0, 0);
      k++;
    end while (!hif.issue && k < 8);
    if (!hif.issue) chk("issue_bound", 32'(hif.issue), 32'd1);
  endtask

  initial begin
    model_clear();
    rst = 1'b1;
    hif.id_valid = 0; hif.id_opcode = '0; hif.id_rs1_index = '0;
    hif.id_rs2_index = '0; hif.id_rd_index = '0; hif.ex_branch_taken = 0;

    step(0, OPC_OP, 0, 0, 0, 0, 1);
    step(1, OPC_OP, 1, 2, 3, 1, 1);      // reset forces controls low

    // Load-use: lw x5 ; add x6,x5,x1
    step(1, OPC_LOAD, 1, 0, 5, 0, 0);
    issue_until(OPC_OP, 5, 1, 6);
    step(0, OPC_OP, 0, 0, 0, 0, 0);
    // Back-to-back ALU: add x3,x1,x2 ; sub x4,x3,x3
    step(1, OPC_OP, 1, 2, 3, 0, 0);
    issue_until(OPC_OP, 3, 3, 4);
    step(0, OPC_OP, 0, 0, 0, 0, 0);
    // x0 producer: addi x0,x1,5 ; add x7,x0,x0
    step(1, OPC_OPIMM, 1, 0, 0, 0, 0);
    step(1, OPC_OP, 0, 0, 7, 0, 0);
    step(0, OPC_OP, 0, 0, 0, 0, 0);
    // Branch/stall collision
    step(1, OPC_LOAD, 1, 0, 5, 0, 0);
    step(1, OPC_OP, 5, 1, 6, 1, 0);
    step(1, OPC_OP, 5, 1, 6, 0, 0);      // EX now a bubble: no load-use
    // add x3 ; or x8,x3,x0
    step(1, OPC_OP, 1, 2, 3, 0, 0);
    issue_until(OPC_OP, 3, 0, 8);
    step(0, OPC_OP, 0, 0, 0, 0, 0);
    // Reset in the middle of a stall
    step(1, OPC_LOAD, 1, 0, 5, 0, 0);
    step(1, OPC_OP, 5, 5, 6, 0, 0);
    step(1, OPC_OP, 5, 5, 6, 0, 1);
    step(1, OPC_OP, 5, 5, 6, 0, 0);

    // Randomized traffic on a small register set to force collisions
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 7) != 0, opcs[$urandom_range(0, 9)],
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
           $urandom_range(0, 299) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
